// File: rtl/jtag_tap_pkg.sv
// Shared definitions for the JTAG TAP controller: state encoding, default
// opcodes, data-register selector and the TAP transition function.
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      TLR    = 4'd0,
      RTI    = 4'd1,
      SEL_DR = 4'd2,
      CAP_DR = 4'd3,
      SH_DR  = 4'd4,
      EX1_DR = 4'd5,
      PAU_DR = 4'd6,
      EX2_DR = 4'd7,
      UPD_DR = 4'd8,
      SEL_IR = 4'd9,
      CAP_IR = 4'd10,
      SH_IR  = 4'd11,
      EX1_IR = 4'd12,
      PAU_IR = 4'd13,
      EX2_IR = 4'd14,
      UPD_IR = 4'd15
   } tap_state_t;

   typedef enum logic [1:0] {
      DR_BYPASS   = 2'd0,
      DR_IDCODE   = 2'd1,
      DR_BOUNDARY = 2'd2
   } dr_sel_t;

   localparam logic [3:0]  DEF_OP_EXTEST = 4'h0;
   localparam logic [3:0]  DEF_OP_SAMPLE = 4'h1;
   localparam logic [3:0]  DEF_OP_IDCODE = 4'h2;
   localparam logic [3:0]  DEF_OP_BYPASS = 4'hF;
   localparam logic [31:0] DEF_IDCODE    = 32'h1000_0001;

   // The CAP/SH/EX1/PAU/EX2/UPD pattern is identical for both branches.
   function automatic tap_state_t next_state(input tap_state_t state, input logic tms);
      tap_state_t nxt;
      nxt = TLR;
      unique case (state)
         TLR:    nxt = tms ? TLR    : RTI;
         RTI:    nxt = tms ? SEL_DR : RTI;
         SEL_DR: nxt = tms ? SEL_IR : CAP_DR;
         CAP_DR: nxt = tms ? EX1_DR : SH_DR;
         SH_DR:  nxt = tms ? EX1_DR : SH_DR;
         EX1_DR: nxt = tms ? UPD_DR : PAU_DR;
         PAU_DR: nxt = tms ? EX2_DR : PAU_DR;
         EX2_DR: nxt = tms ? UPD_DR : SH_DR;
         UPD_DR: nxt = tms ? SEL_DR : RTI;
         SEL_IR: nxt = tms ? TLR    : CAP_IR;
         CAP_IR: nxt = tms ? EX1_IR : SH_IR;
         SH_IR:  nxt = tms ? EX1_IR : SH_IR;
         EX1_IR: nxt = tms ? UPD_IR : PAU_IR;
         PAU_IR: nxt = tms ? EX2_IR : PAU_IR;
         EX2_IR: nxt = tms ? UPD_IR : SH_IR;
         UPD_IR: nxt = tms ? SEL_DR : RTI;
         default: nxt = TLR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine: state register, TMS transition logic and
// one-hot style decode flags for the states the datapath cares about.
module jtag_tap_fsm import jtag_tap_pkg::*; (
   input  logic       tck,
   input  logic       trst_n,
   input  logic       tms,
   output tap_state_t state,
   output logic       is_tlr,
   output logic       is_cap_dr,
   output logic       is_sh_dr,
   output logic       is_cap_ir,
   output logic       is_sh_ir,
   output logic       is_upd_ir
);

   tap_state_t state_next;

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         state <= TLR;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = next_state(state, tms);
   end

   always_comb begin
      is_tlr    = (state == TLR);
      is_cap_dr = (state == CAP_DR);
      is_sh_dr  = (state == SH_DR);
      is_cap_ir = (state == CAP_IR);
      is_sh_ir  = (state == SH_IR);
      is_upd_ir = (state == UPD_IR);
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller for an observe-only boundary chain: IR, bypass
// and IDCODE registers, boundary cell controls and the falling-edge TDO mux.
module jtag_tap_ctrl import jtag_tap_pkg::*; #(
   parameter int                  IR_WIDTH  = 4,
   parameter logic [31:0]         IDCODE    = DEF_IDCODE,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(DEF_OP_EXTEST),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(DEF_OP_SAMPLE),
   parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(DEF_OP_IDCODE),
   parameter logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(DEF_OP_BYPASS)
) (
   input  logic       tck,
   input  logic       trst_n,
   input  logic       tms,
   input  logic       tdi,
   output logic       tdo,
   output logic       tdo_en,
   output logic       bs_si,
   input  logic       bs_so,
   output logic       capture_en,
   output logic       shift_dr,
   output logic       extest,
   output logic [3:0] tap_state
);

   localparam logic [31:0]         ID_VALUE   = IDCODE | 32'd1;
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, 2'b01};

   tap_state_t          state;
   logic                is_tlr;
   logic                is_cap_dr;
   logic                is_sh_dr;
   logic                is_cap_ir;
   logic                is_sh_ir;
   logic                is_upd_ir;

   logic [IR_WIDTH-1:0] ir_shift;
   logic [IR_WIDTH-1:0] ir_active;
   logic                bypass_reg;
   logic [31:0]         id_reg;
   dr_sel_t             dr_sel;
   logic                tdo_next;

   jtag_tap_fsm u_fsm (
      .tck       (tck),
      .trst_n    (trst_n),
      .tms       (tms),
      .state     (state),
      .is_tlr    (is_tlr),
      .is_cap_dr (is_cap_dr),
      .is_sh_dr  (is_sh_dr),
      .is_cap_ir (is_cap_ir),
      .is_sh_ir  (is_sh_ir),
      .is_upd_ir (is_upd_ir)
   );

   // The capture pattern ends in 01 so a board tester can locate the IR
   // boundary in a chain of devices.
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         ir_shift <= '0;
      end else if (is_cap_ir) begin
         ir_shift <= IR_CAPTURE;
      end else if (is_sh_ir) begin
         ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      end
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         ir_active <= OP_IDCODE;
      end else if (is_tlr) begin
         ir_active <= OP_IDCODE;
      end else if (is_upd_ir) begin
         ir_active <= ir_shift;
      end
   end

   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         bypass_reg <= 1'b0;
         id_reg     <= ID_VALUE;
      end else if (is_cap_dr) begin
         bypass_reg <= 1'b0;
         id_reg     <= ID_VALUE;
      end else if (is_sh_dr) begin
         bypass_reg <= tdi;
         id_reg     <= {tdi, id_reg[31:1]};
      end
   end

   // Any opcode not explicitly recognised falls through to bypass.
   always_comb begin
      if ((ir_active == OP_EXTEST) || (ir_active == OP_SAMPLE)) begin
         dr_sel = DR_BOUNDARY;
      end else if (ir_active == OP_IDCODE) begin
         dr_sel = DR_IDCODE;
      end else begin
         dr_sel = DR_BYPASS;
      end
   end

   always_comb begin
      tdo_next = 1'b0;
      if (is_sh_ir) begin
         tdo_next = ir_shift[0];
      end else if (is_sh_dr) begin
         unique case (dr_sel)
            DR_BOUNDARY: tdo_next = bs_so;
            DR_IDCODE:   tdo_next = id_reg[0];
            default:     tdo_next = bypass_reg;
         endcase
      end
   end

   // TDO changes on the falling edge so the next device samples it stably.
   always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n) begin
         tdo    <= 1'b0;
         tdo_en <= 1'b0;
      end else begin
         tdo    <= tdo_next;
         tdo_en <= is_sh_dr | is_sh_ir;
      end
   end

   assign bs_si      = tdi;
   assign capture_en = ~((dr_sel == DR_BOUNDARY) & (is_cap_dr | is_sh_dr));
   assign shift_dr   = is_sh_dr;
   assign extest     = (ir_active == OP_EXTEST);
   assign tap_state  = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomised scoreboard bench for jtag_tap_ctrl: a table-driven TAP model
// with queue-based registers predicts controls and TDO bits per cycle.
module tb_jtag_tap_ctrl;

   localparam int IRW = 4;

   logic       tck;
   logic       trst_n;
   logic       tms;
   logic       tdi;
   logic       tdo;
   logic       tdo_en;
   logic       bs_si;
   logic       bs_so;
   logic       capture_en;
   logic       shift_dr;
   logic       extest;
   logic [3:0] tap_state;

   typedef struct {
      logic [3:0] st;
      logic       cap;
      logic       shd;
      logic       ext;
      logic       ten;
   } ctl_t;

   ctl_t ctl_q[$];
   logic tdo_q[$];
   int   total;
   int   bad;

   int   m_state;
   int   m_ir;
   bit   dq[$];
   bit   iq[$];
   int   nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int   nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
   logic [31:0] id_val;

   jtag_tap_ctrl dut (
      .tck        (tck),
      .trst_n     (trst_n),
      .tms        (tms),
      .tdi        (tdi),
      .tdo        (tdo),
      .tdo_en     (tdo_en),
      .bs_si      (bs_si),
      .bs_so      (bs_so),
      .capture_en (capture_en),
      .shift_dr   (shift_dr),
      .extest     (extest),
      .tap_state  (tap_state)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit isBoundary(input int ir);
      return (ir == 0) || (ir == 1);
   endfunction

   function automatic ctl_t expectCtl();
      ctl_t c;
      c.st  = 4'(m_state);
      c.cap = !(isBoundary(m_ir) && (m_state == 3 || m_state == 4));
      c.shd = (m_state == 4);
      c.ext = (m_ir == 0);
      c.ten = (m_state == 4) || (m_state == 11);
      return c;
   endfunction

   // One tck cycle: drive pins, advance the reference model, queue predictions.
   task automatic applyStimulus(input logic t_ms, input logic t_di, input logic t_bso);
      bit dummy;
      @(negedge tck);
      #2;
      tms   = t_ms;
      tdi   = t_di;
      bs_so = t_bso;
      case (m_state)
         0: m_ir = 2;
         3: begin
            dq.delete();
            if (m_ir == 2) begin
               for (int i = 0; i < 32; i++) dq.push_back(id_val[i]);
            end else if (!isBoundary(m_ir)) begin
               dq.push_back(1'b0);
            end
         end
         4: begin
            if (dq.size() > 0) begin
               dummy = dq.pop_front();
               dq.push_back(t_di);
            end
         end
         10: begin
            iq.delete();
            for (int i = 0; i < IRW; i++) iq.push_back(i == 0);
         end
         11: begin
            if (iq.size() > 0) begin
               dummy = iq.pop_front();
               iq.push_back(t_di);
            end
         end
         15: begin
            m_ir = 0;
            foreach (iq[i]) if (iq[i]) m_ir |= (1 << i);
         end
         default: ;
      endcase
      m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
      ctl_q.push_back(expectCtl());
      if (m_state == 11) begin
         tdo_q.push_back((iq.size() > 0) ? logic'(iq[0]) : 1'b0);
      end else if (m_state == 4) begin
         if (isBoundary(m_ir)) tdo_q.push_back(t_bso);
         else tdo_q.push_back((dq.size() > 0) ? logic'(dq[0]) : 1'b0);
      end
   endtask

   task automatic applyReset();
      @(negedge tck);
      #2;
      trst_n = 1'b0;
      tms    = 1'b1;
      tdi    = 1'b0;
      #1;
      checkOutput("rst_state", 32'(tap_state), 32'd0);
      checkOutput("rst_tdo", 32'(tdo), 32'd0);
      checkOutput("rst_tdo_en", 32'(tdo_en), 32'd0);
      checkOutput("rst_capture_en", 32'(capture_en), 32'd1);
      checkOutput("rst_shift_dr", 32'(shift_dr), 32'd0);
      checkOutput("rst_extest", 32'(extest), 32'd0);
      m_state = 0;
      m_ir    = 2;
      dq.delete();
      iq.delete();
      ctl_q.push_back(expectCtl());
      @(posedge tck);
      #2;
      trst_n = 1'b1;
   endtask

   // From RTI: load an opcode through SH_IR and return to RTI.
   task automatic loadIr(input logic [IRW-1:0] op);
      applyStimulus(1'b1, 1'b0, 1'($urandom));
      applyStimulus(1'b1, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b0, 1'($urandom));
      for (int i = 0; i < IRW; i++) applyStimulus(i == IRW - 1, op[i], 1'($urandom));
      applyStimulus(1'b1, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b0, 1'($urandom));
   endtask

   // From RTI: shift n DR bits from pat (LSB first), optionally pausing.
   task automatic shiftDr(input int n, input int pause_at, input logic [63:0] pat);
      bit last;
      bit brk;
      applyStimulus(1'b1, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b0, 1'($urandom));
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         brk  = (i == pause_at) && !last;
         applyStimulus(last || brk, pat[i], 1'($urandom));
         if (brk) begin
            repeat (3) applyStimulus(1'b0, 1'($urandom), 1'($urandom));
            applyStimulus(1'b1, 1'($urandom), 1'($urandom));
            applyStimulus(1'b0, 1'($urandom), 1'($urandom));
         end
      end
      applyStimulus(1'b1, 1'b0, 1'($urandom));
      applyStimulus(1'b0, 1'b0, 1'($urandom));
   endtask

   // Monitor: compares controls every cycle and TDO whenever tdo_en is high.
   initial begin
      ctl_t e;
      logic t;
      forever begin
         @(negedge tck);
         #1;
         if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            checkOutput("tap_state", 32'(tap_state), 32'(e.st));
            checkOutput("capture_en", 32'(capture_en), 32'(e.cap));
            checkOutput("shift_dr", 32'(shift_dr), 32'(e.shd));
            checkOutput("extest", 32'(extest), 32'(e.ext));
            checkOutput("tdo_en", 32'(tdo_en), 32'(e.ten));
         end
         if (tdo_en === 1'b1) begin
            if (tdo_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL tdo_unexpected: got tdo_en=1 expected no shift at %0t", $time);
            end else begin
               t = tdo_q.pop_front();
               checkOutput("tdo", 32'(tdo), 32'(t));
            end
         end
      end
   end

   initial begin
      logic [IRW-1:0] ops[6];
      total  = 0;
      bad    = 0;
      trst_n = 1'b0;
      tms    = 1'b1;
      tdi    = 1'b0;
      bs_so  = 1'b0;
      id_val = 32'h1000_0001 | 32'd1;
      ops[0] = 4'h0;
      ops[1] = 4'h1;
      ops[2] = 4'h2;
      ops[3] = 4'hF;
      ops[4] = 4'h7;
      ops[5] = 4'h0;

      applyReset();
      // Walk into SH_DR, then five tms=1 clocks must land in TLR.
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      shiftDr(32, -1, {$urandom, $urandom});
      loadIr(4'hF);
      shiftDr(4, -1, 64'hD);
      loadIr(4'h1);
      shiftDr(8, 3, {$urandom, $urandom});
      loadIr(4'h0);
      shiftDr(5, -1, {$urandom, $urandom});
      loadIr(4'h7);
      shiftDr(6, 2, {$urandom, $urandom});
      loadIr(4'h2);
      shiftDr(40, 10, {$urandom, $urandom});

      // Abort an IR shift with trst_n; IR must stay at IDCODE.
      loadIr(4'h0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyReset();
      applyStimulus(1'b0, 1'b0, 1'b0);
      shiftDr(32, -1, {$urandom, $urandom});

      for (int k = 0; k < 30; k++) begin
         if (k % 3 == 0) loadIr(IRW'($urandom));
         else loadIr(ops[$urandom_range(0, 5)]);
         shiftDr($urandom_range(1, 40), $urandom_range(0, 45), {$urandom, $urandom});
      end

      for (int k = 0; k < 300; k++) begin
         if (k == 150) applyReset();
         applyStimulus(1'($urandom_range(0, 99) < 35), 1'($urandom), 1'($urandom));
      end
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      @(negedge tck);
      #3;
      checkOutput("ctl_q_drain", 32'(ctl_q.size()), 32'd0);
      checkOutput("tdo_q_drain", 32'(tdo_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
